md_seq_ctrl: RTL and testbench
==============================

Name: md_seq_ctrl

Overview:
- Sequencing controller for the multiply/divide resource beside the E stage of the 5-stage MIPS pipeline.
- Decodes the mult/div family from instr_E and launches fixed-latency mult/multu/div/divu operations.
- Tracks busy with a down-counter and commits HI/LO at completion.
- Raises md_stall toward the hazard unit whenever the D-stage instruction needs the resource before it is free.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal 1..15)
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- instr_D  in  32  instruction in D stage; used only for stall decode
- instr_E  in  32  instruction in E stage; bubbles are 32'h0
- rs_E  in  32  forwarded rs operand in E
- rt_E  in  32  forwarded rt operand in E
- busy  out  1  operation in flight
- md_stall  out  1  hold F/D and bubble E this cycle
- hi_out  out  32  architectural HI
- lo_out  out  32  architectural LO
- err_overlap  out  1  sticky flag: md op in E while busy

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high. On reset: busy=0, count=0, hi_out=0, lo_out=0, err_overlap=0, pending op cleared.
- Decode (opcode 000000, funct):
  - start ops: mult 011000, multu 011001, div 011010, divu 011011
  - move-to ops: mthi 010001, mtlo 010011
  - move-from ops: mfhi 010000, mflo 010010
  - md-family = start ops | move-to ops | move-from ops
- start_E = instr_E is a start op and busy==0.
- Launch, edge ending cycle T with start_E=1:
  - latch the operation and rs_E/rt_E into pending registers
  - count <= MULT_CYCLES or DIV_CYCLES
  - busy <= 1
- Countdown: while busy, count decrements each edge. At the edge where count==1, HI/LO commit and busy <= 0. busy is therefore high for exactly N cycles (T+1..T+N) and HI/LO are new from cycle T+N+1.
- Result rules:
  - mult: signed 64-bit product; multu: unsigned 64-bit product. HI = product[63:32], LO = product[31:0].
  - div: signed. LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - rt_E==0 for div/divu: busy sequence runs normally; HI/LO left unchanged at commit.
  - div 0x80000000 / -1: LO = 0x80000000, HI = 0.
- Move-to ops: mthi/mtlo with busy==0 write rs_E into HI/LO at the edge ending that cycle; no busy.
- Move-from ops: mfhi/mflo read hi_out/lo_out directly; this block does no separate forwarding.
- md_stall = (instr_D is md-family) and (busy or start_E). It is combinational, so no md-family instruction ever reaches E while busy.
- Overlap error: an md-family instruction in E while busy=1 is a hazard-unit fault. The op is ignored (no launch, no HI/LO write) and err_overlap is set and stays set until reset.
- Reset mid-operation: the in-flight op is discarded and HI/LO return to 0.
- Non-md instructions in E or D have no effect.

Decomposition:
- Shared package md_pkg:
  - funct constants FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO, FN_MFHI, FN_MFLO
  - OP_SPECIAL
  - 2-bit op enum MD_MULT/MD_MULTU/MD_DIV/MD_DIVU
- One sub-module, md_decode: combinational classification of a 32-bit instruction into is_start, is_mt, is_mf and op. Instantiated twice, once for D and once for E.
- The counter, pending registers and HI/LO stay in md_seq_ctrl.

Test Plan:
- mult: rs_E=-3, rt_E=7 at cycle T -> busy high T+1..T+5; HI=0xFFFFFFFF, LO=0xFFFFFFEB from T+6.
- divu: rs_E=100, rt_E=7, with mflo held in D -> md_stall=1 for cycles T..T+10; LO=14, HI=2 at T+11, then md_stall=0.
- div: rs_E=-7, rt_E=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then div by zero with rt_E=0 -> busy still runs 10 cycles; HI/LO unchanged.
- mthi with rs_E=0xDEADBEEF while idle -> hi_out=0xDEADBEEF next cycle, busy stays 0. Next instruction mfhi in D -> no stall.
- Force mult in E while busy (hazard unit bypassed) -> no relaunch, HI/LO unaffected by the forced op, err_overlap=1 and sticky.
- Assert reset at count==3 of a div -> busy=0, hi_out=lo_out=0 immediately; a new mult launches normally afterward.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: shared encodings for the multiply/divide sequencing block.
//   - OP_SPECIAL: primary opcode of the R-type mult/div family
//   - FN_*: funct field values of the mult/div family
//   - md_op_e: 2-bit pending operation code. Its values equal funct[1:0]
//     of the four start ops, so the decoder can cast that field directly.
package md_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

endpackage

// File: rtl/md_decode.sv
// md_decode: combinational classification of one 32-bit instruction into
// the multiply/divide family.
//   instr    in   instruction word
//   is_start out  mult/multu/div/divu
//   is_mt    out  mthi/mtlo
//   is_mf    out  mfhi/mflo
//   mt_hi    out  when is_mt: 1 = mthi, 0 = mtlo
//   op       out  start op code (meaningful only when is_start)
module md_decode
  import md_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_start,
  output logic        is_mt,
  output logic        is_mf,
  output logic        mt_hi,
  output md_op_e      op
);

  logic       special;
  logic [5:0] funct;
  // rs/rt/rd/shamt fields do not take part in classification.
  logic       unused_fields;

  assign special       = (instr[31:26] == OP_SPECIAL);
  assign funct         = instr[5:0];
  assign unused_fields = ^instr[25:6];

  always_comb begin
    is_start = special && ((funct == FN_MULT) || (funct == FN_MULTU) ||
                           (funct == FN_DIV)  || (funct == FN_DIVU));
    is_mt    = special && ((funct == FN_MTHI) || (funct == FN_MTLO));
    is_mf    = special && ((funct == FN_MFHI) || (funct == FN_MFLO));
    mt_hi    = (funct == FN_MTHI);
    op       = md_op_e'(funct[1:0]);
  end

endmodule

// File: rtl/md_seq_ctrl.sv
// md_seq_ctrl: sequencing controller for the fixed-latency multiply/divide
// resource beside the E stage.
//   clk         in   pipeline clock, rising edge
//   reset       in   asynchronous, active-high; clears all state
//   instr_D     in   D-stage instruction (stall decode only)
//   instr_E     in   E-stage instruction (bubble = 32'h0)
//   rs_E, rt_E  in   forwarded operands in E
//   busy        out  operation in flight
//   md_stall    out  hold F/D and bubble E this cycle
//   hi_out      out  architectural HI
//   lo_out      out  architectural LO
//   err_overlap out  sticky: md-family op seen in E while busy
//
// Launch/stall contract: a start op in E is accepted in the cycle it is
// seen only if busy==0 (start_E). busy then stays high for exactly N cycles
// and HI/LO carry the result from the cycle after busy falls. md_stall is
// combinational so the hazard unit holds any md-family op in D until the
// resource is idle; one arriving in E anyway is dropped and flagged.
module md_seq_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_D,
  input  logic [31:0] instr_E,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        err_overlap
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Decode of both stages
  logic   d_start, d_mt, d_mf, d_mt_hi;
  md_op_e d_op;
  logic   e_start, e_mt, e_mf, e_mt_hi;
  md_op_e e_op;

  md_decode u_dec_d (
    .instr    (instr_D),
    .is_start (d_start),
    .is_mt    (d_mt),
    .is_mf    (d_mf),
    .mt_hi    (d_mt_hi),
    .op       (d_op)
  );

  md_decode u_dec_e (
    .instr    (instr_E),
    .is_start (e_start),
    .is_mt    (e_mt),
    .is_mf    (e_mf),
    .mt_hi    (e_mt_hi),
    .op       (e_op)
  );

  // The D decode only needs family membership.
  logic unused_d;
  assign unused_d = ^{d_mt_hi, d_op};

  logic d_is_md, e_is_md;
  logic start_e, mt_e, overlap_e;

  assign d_is_md   = d_start | d_mt | d_mf;
  assign e_is_md   = e_start | e_mt | e_mf;
  assign start_e   = e_start & ~busy;
  assign mt_e      = e_mt & ~busy;
  assign overlap_e = e_is_md & busy;
  assign md_stall  = d_is_md & (busy | start_e);

  // Pending operation and countdown
  md_op_e           pend_op;
  logic [31:0]      pend_a, pend_b;
  logic [CNT_W-1:0] count;
  logic             commit;

  assign commit = busy && (count == CNT_ONE);

  // Result datapath, evaluated from the pending registers
  logic        is_signed_op, is_div_op;
  logic [63:0] mul_a, mul_b, product;
  logic        a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, b_safe, quo, rem;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  always_comb begin
    is_signed_op = (pend_op == MD_MULT) || (pend_op == MD_DIV);
    is_div_op    = (pend_op == MD_DIV) || (pend_op == MD_DIVU);

    mul_a   = is_signed_op ? {{32{pend_a[31]}}, pend_a} : {32'd0, pend_a};
    mul_b   = is_signed_op ? {{32{pend_b[31]}}, pend_b} : {32'd0, pend_b};
    product = mul_a * mul_b;

    // Signed divide runs on magnitudes. |0x80000000| is still 0x80000000
    // as an unsigned value, so 0x80000000 / -1 yields LO=0x80000000, HI=0
    // with no special case.
    a_neg    = is_signed_op & pend_a[31];
    b_neg    = is_signed_op & pend_b[31];
    a_mag    = a_neg ? (32'd0 - pend_a) : pend_a;
    b_mag    = b_neg ? (32'd0 - pend_b) : pend_b;
    div_zero = (pend_b == 32'd0);
    b_safe   = div_zero ? 32'd1 : b_mag;
    quo      = a_mag / b_safe;
    rem      = a_mag % b_safe;

    if (is_div_op) begin
      res_lo = (a_neg ^ b_neg) ? (32'd0 - quo) : quo;
      res_hi = a_neg ? (32'd0 - rem) : rem;
    end else begin
      res_lo = product[31:0];
      res_hi = product[63:32];
    end

    // Divide by zero runs its full latency but leaves HI/LO untouched.
    res_wr = ~(is_div_op & div_zero);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= 1'b0;
      count       <= '0;
      pend_op     <= MD_MULT;
      pend_a      <= '0;
      pend_b      <= '0;
      hi_out      <= '0;
      lo_out      <= '0;
      err_overlap <= 1'b0;
    end else begin
      if (overlap_e) begin
        err_overlap <= 1'b1;
      end

      if (start_e) begin
        pend_op <= e_op;
        pend_a  <= rs_E;
        pend_b  <= rt_E;
        count   <= e_op[1] ? DIV_LD : MULT_LD;
        busy    <= 1'b1;
      end else if (busy) begin
        count <= count - CNT_ONE;
        if (commit) begin
          busy <= 1'b0;
          if (res_wr) begin
            hi_out <= res_hi;
            lo_out <= res_lo;
          end
        end
      end

      // Only reachable while idle, so it never collides with a commit.
      if (mt_e) begin
        if (e_mt_hi) hi_out <= rs_E;
        else         lo_out <= rs_E;
      end
    end
  end

endmodule

// File: tb/tb_md_seq_ctrl.sv
// tb_md_seq_ctrl: directed bench for md_seq_ctrl. Expected HI/LO pairs are
// pushed when an op is issued; a negedge monitor pops and compares them
// whenever busy falls outside reset.
module tb_md_seq_ctrl;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] instr_d = 32'd0;
  logic [31:0] instr_e = 32'd0;
  logic [31:0] rs_e    = 32'd0;
  logic [31:0] rt_e    = 32'd0;
  logic        busy, md_stall, err_overlap;
  logic [31:0] hi_out, lo_out;

  md_seq_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk         (clk),
    .reset       (rst),
    .instr_D     (instr_d),
    .instr_E     (instr_e),
    .rs_E        (rs_e),
    .rt_E        (rt_e),
    .busy        (busy),
    .md_stall    (md_stall),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .err_overlap (err_overlap)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] funct);
    return {26'd0, funct};
  endfunction

  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV  = 6'b011010, F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI = 6'b010001, F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO  = 6'b010010;

  // Scoreboard: {HI, LO} expected after each completion
  logic [63:0] exp_q[$];
  bit          prev_busy = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", {hi_out, lo_out}, 64'hx);
        end else begin
          chk("result", {hi_out, lo_out}, exp_q.pop_front());
        end
      end
      prev_busy = busy;
    end
  end

  // Driver: issue one start op in E, optionally inject a forced md op in
  // the first busy cycle, and check busy length and stall every cycle.
  task automatic run_op(input string name, input logic [31:0] ie,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] id, input bit id_md,
                        input int exp_n, input bit inject,
                        input logic [63:0] exp_res);
    int n;
    instr_d = id;
    instr_e = ie;
    rs_e    = a;
    rt_e    = b;
    exp_q.push_back(exp_res);
    #1;
    chk({name, "_stall_launch"}, 64'(md_stall), 64'(id_md));
    @(posedge clk); #1;
    instr_e = 32'd0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      chk({name, "_stall_busy"}, 64'(md_stall), 64'(id_md));
      if (inject && n == 1) begin
        instr_e = mk(F_MULT);
        rs_e    = 32'd1000;
        rt_e    = 32'd1000;
      end else begin
        instr_e = 32'd0;
      end
      @(posedge clk); #1;
    end
    chk({name, "_busy_len"}, 64'(n), 64'(exp_n));
    chk({name, "_stall_after"}, 64'(md_stall), 64'd0);
    instr_d = 32'd0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   64'(busy),        64'd0);
    chk("rst_stall",  64'(md_stall),    64'd0);
    chk("rst_hi",     64'(hi_out),      64'd0);
    chk("rst_lo",     64'(lo_out),      64'd0);
    chk("rst_err",    64'(err_overlap), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // mult -3 * 7 = -21
    run_op("mult", mk(F_MULT), 32'hFFFF_FFFD, 32'd7, 32'd0, 1'b0, 5, 1'b0,
           {32'hFFFF_FFFF, 32'hFFFF_FFEB});

    // divu 100 / 7 with mflo waiting in D
    run_op("divu", mk(F_DIVU), 32'd100, 32'd7, mk(F_MFLO), 1'b1, 10, 1'b0,
           {32'd2, 32'd14});

    // div -7 / 2: quotient -3, remainder -1
    run_op("div", mk(F_DIV), 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 10, 1'b0,
           {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    // div by zero: full latency, HI/LO unchanged
    run_op("div0", mk(F_DIV), 32'd123, 32'd0, mk(F_MFHI), 1'b1, 10, 1'b0,
           {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    // div 0x80000000 / -1
    run_op("div_ovf", mk(F_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 10, 1'b0,
           {32'h0000_0000, 32'h8000_0000});

    // multu 0xFFFFFFFF * 2
    run_op("multu", mk(F_MULTU), 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 5, 1'b0,
           {32'h0000_0001, 32'hFFFF_FFFE});

    // mthi while idle, mfhi following in D
    instr_e = mk(F_MTHI);
    rs_e    = 32'hDEAD_BEEF;
    instr_d = mk(F_MFHI);
    #1;
    chk("mthi_stall", 64'(md_stall), 64'd0);
    @(posedge clk); #1;
    instr_e = 32'd0;
    chk("mthi_hi",    64'(hi_out),   64'h0000_0000_DEAD_BEEF);
    chk("mthi_lo",    64'(lo_out),   64'h0000_0000_FFFF_FFFE);
    chk("mthi_busy",  64'(busy),     64'd0);
    chk("mfhi_stall", 64'(md_stall), 64'd0);
    instr_e = mk(F_MTLO);
    rs_e    = 32'h0BAD_F00D;
    instr_d = 32'd0;
    @(posedge clk); #1;
    instr_e = 32'd0;
    chk("mtlo_lo", 64'(lo_out), 64'h0000_0000_0BAD_F00D);
    chk("mtlo_hi", 64'(hi_out), 64'h0000_0000_DEAD_BEEF);

    // mult 6 * 7 with a forced mult in E during the first busy cycle
    chk("err_before", 64'(err_overlap), 64'd0);
    run_op("overlap", mk(F_MULT), 32'd6, 32'd7, 32'd0, 1'b0, 5, 1'b1,
           {32'd0, 32'd42});
    chk("err_set", 64'(err_overlap), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", 64'(err_overlap), 64'd1);

    // Reset in the cycle where the div counter reads 3
    instr_e = mk(F_DIV);
    rs_e    = 32'd50;
    rt_e    = 32'd5;
    @(posedge clk); #1;
    instr_e = 32'd0;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy),        64'd0);
    chk("midrst_hi",   64'(hi_out),      64'd0);
    chk("midrst_lo",   64'(lo_out),      64'd0);
    chk("midrst_err",  64'(err_overlap), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("mult_after_rst", mk(F_MULT), 32'd2, 32'd3, 32'd0, 1'b0, 5, 1'b0,
           {32'd0, 32'd6});

    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
